// File: rtl/param_seq_detector.sv
// Programmable serial pattern detector with overlapping/non-overlapping matching,
// a saturating match counter and a sticky match flag.
module param_seq_detector #(
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 16,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             match_seen,
    output logic             armed,
    output logic             cfg_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] ARMED = 2'd2;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    logic [1:0]       state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic             err_q, err_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seen_q, seen_d;

    logic [PAT_W-1:0] hist_sh;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill_inc;
    logic             eq;
    logic             hit;

    always_comb begin
        hist_sh  = {hist_q[PAT_W-2:0], in_bit};
        fill_inc = (fill_q == LEN_MAX) ? fill_q : fill_q + 1'b1;
        mask     = '0;
        for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(len_q));
        eq       = ((hist_sh ^ pat_q) & mask) == '0;
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        err_d   = err_q;
        hit     = 1'b0;
        if (!en) begin
            state_d = IDLE;
            hist_d  = '0;
            fill_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FILL;
                    pat_d   = cfg_pattern;
                    len_d   = cfg_len;
                    ovl_d   = cfg_overlap;
                    err_d   = (cfg_len == '0) || (cfg_len > LEN_MAX);
                    hist_d  = '0;
                    fill_d  = '0;
                end
                FILL: if (in_valid) begin
                    hist_d = hist_sh;
                    fill_d = fill_inc;
                    // The beat that completes the fill is already a compare beat.
                    if (!err_q && fill_inc == len_q) begin
                        hit = eq;
                        if (eq && !ovl_q) begin
                            hist_d = '0;
                            fill_d = '0;
                        end else begin
                            state_d = ARMED;
                        end
                    end
                end
                ARMED: if (in_valid) begin
                    hist_d = hist_sh;
                    hit    = eq;
                    if (eq && !ovl_q) begin
                        hist_d  = '0;
                        fill_d  = '0;
                        state_d = FILL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        match_d = hit;
        cnt_d   = cnt_q;
        seen_d  = seen_q | hit;
        if (hit && cnt_q != '1) cnt_d = cnt_q + 1'b1;
        // clr takes priority over a coincident match.
        if (clr) begin
            cnt_d  = '0;
            seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            err_q   <= 1'b0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            err_q   <= err_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
        end
    end

    assign match      = match_q;
    assign match_cnt  = cnt_q;
    assign match_seen = seen_q;
    assign armed      = (state_q == ARMED);
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// Scoreboard bench for param_seq_detector: stimulus pushes expected pulses,
// a negedge monitor pops and compares on every match pulse.
module tb_param_seq_detector;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = $clog2(PAT_W + 1);

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             seen;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             in_valid;
    logic             in_bit;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             clr;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             match_seen;
    logic             armed;
    logic             cfg_err;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_on = 1'b0;

    param_seq_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .clr(clr), .match(match), .match_cnt(match_cnt), .match_seen(match_seen),
        .armed(armed), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Monitor: every match pulse must correspond to a queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on && !rst && match) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_match: got match cnt=%0d, required no match", match_cnt);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (match_cnt !== e.cnt || match_seen !== e.seen) begin
                        errors++;
                        $display("FAIL match_status: got cnt=%0d seen=%0b, required cnt=%0d seen=%0b",
                                 match_cnt, match_seen, e.cnt, e.seen);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int cnt, input bit seen);
        exp_t e;
        e.cnt  = CNT_W'(cnt);
        e.seen = seen;
        exp_q.push_back(e);
    endtask

    task automatic beat(input bit b);
        in_valid = 1'b1;
        in_bit   = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        @(negedge clk);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic start(input logic [PAT_W-1:0] pat, input int len, input bit ovl);
        en          = 1'b0;
        clr         = 1'b1;
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        @(negedge clk);
        clr = 1'b0;
        en  = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_match", match, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_seen", match_seen, 0);
        chk("rst_armed", armed, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);

        // Overlap on: 1 x5 -> matches after beats 3,4,5.
        start(8'b111, 3, 1'b1);
        beat(1); beat(1);
        chk("ovl_not_armed_early", armed, 0);
        push(1, 1); beat(1);
        chk("ovl_armed", armed, 1);
        push(2, 1); beat(1);
        push(3, 1); beat(1);
        chk("ovl_cnt", match_cnt, 3);
        drain("ovl_all_pulses");

        // Overlap off: 1 x6 -> matches after beats 3 and 6.
        start(8'b111, 3, 1'b0);
        beat(1); beat(1);
        push(1, 1); beat(1);
        beat(1); beat(1);
        push(2, 1); beat(1);
        chk("novl_cnt", match_cnt, 2);
        drain("novl_all_pulses");

        // Pattern order 1011, oldest bit first.
        start(8'b1011, 4, 1'b1);
        beat(1); beat(1); beat(0); beat(1);
        push(1, 1); beat(1);
        drain("order_pulses");
        chk("order_cnt", match_cnt, 1);

        // Same with in_valid gaps.
        start(8'b1011, 4, 1'b1);
        beat(1); @(negedge clk); beat(1); repeat (3) @(negedge clk);
        beat(0); @(negedge clk); beat(1); @(negedge clk);
        push(1, 1); beat(1);
        drain("gap_pulses");
        chk("gap_cnt", match_cnt, 1);

        // Saturation at CNT_W=2, then clr coincident with the 6th match.
        start(8'b1, 1, 1'b1);
        push(1, 1); beat(1);
        push(2, 1); beat(1);
        push(3, 1); beat(1);
        push(3, 1); beat(1);
        push(3, 1); beat(1);
        clr = 1'b1;
        push(0, 0); beat(1);
        clr = 1'b0;
        chk("clr_cnt", match_cnt, 0);
        chk("clr_seen", match_seen, 0);
        push(1, 1); beat(1);
        drain("sat_pulses");

        // Illegal length: cfg_err set, never armed, no matches.
        start(8'b1, 0, 1'b1);
        chk("err_set", cfg_err, 1);
        repeat (4) beat(1);
        chk("err_not_armed", armed, 0);
        drain("err_no_pulses");
        chk("err_cnt", match_cnt, 0);
        en = 1'b0;
        @(negedge clk);
        chk("err_clears_idle", cfg_err, 0);

        // cfg_len change while enabled is ignored until en re-rises.
        start(8'b111, 3, 1'b1);
        cfg_len = LEN_W'(1);
        beat(1); beat(1);
        push(1, 1); beat(1);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        push(2, 1); beat(1);
        drain("runtime_cfg_pulses");
        chk("runtime_cfg_cnt", match_cnt, 2);

        // Reset mid-pattern aborts the partial match.
        start(8'b111, 3, 1'b0);
        beat(1); beat(1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_cnt", match_cnt, 0);
        @(negedge clk);
        beat(1);
        chk("midrst_armed", armed, 0);
        chk("midrst_match", match, 0);
        beat(1);
        push(1, 1); beat(1);
        beat(1);
        drain("midrst_pulses");
        chk("midrst_cnt_after", match_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
